satatrn_txdma_ctrl: RTL

//  Sequences host->device DMA data FIS transmission for the SATA transport layer.

---
 rtl/satatrn_txdma_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/satatrn_txdma_ctrl.sv
// satatrn_txdma_ctrl
// Host->device DMA data FIS sequencer for the SATA transport layer. A transfer of
// i_len dwords is split into data FISes of at most 2^LGMAXFIS dwords. Each FIS waits
// for a DMA Activate, streams through a one-stage registered pipe towards the TX
// arbiter, and then waits for the link-layer result before the next FIS or completion.
module satatrn_txdma_ctrl #(
    parameter int LGLEN     = 22,
    parameter int LGMAXFIS  = 11,
    parameter int LGTIMEOUT = 20
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [LGLEN-1:0] i_len,
    input  logic             i_abort,
    input  logic             i_dma_activate,
    input  logic             i_link_ok,
    input  logic             i_link_err,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             o_txgate,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_data,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [1:0]       o_errcode
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACT  = 2'd1,
        S_SEND      = 2'd2,
        S_WAIT_LINK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        EC_NONE    = 2'b00,
        EC_LINK    = 2'b01,
        EC_TIMEOUT = 2'b10,
        EC_ABORT   = 2'b11
    } errcode_t;

    // Largest FIS payload, in both the FIS-counter and the length widths.
    // The length width must exceed LGMAXFIS for the zero-extending cast below.
    localparam logic [LGMAXFIS:0] FIS_MAX   = {1'b1, {LGMAXFIS{1'b0}}};
    localparam logic [LGLEN-1:0]  FIS_MAX_L = LGLEN'(FIS_MAX);

    state_t                 state_q, state_d;
    logic [LGLEN-1:0]       remaining_q;
    logic [LGMAXFIS:0]      fis_left_q;
    logic [LGTIMEOUT-1:0]   wd_q;
    logic                   abort_q;

    logic                   accept;      // source beat enters the output register
    logic                   out_fire;    // output beat taken by the arbiter
    logic                   wd_expired;
    logic                   done_evt;
    logic                   err_evt;
    errcode_t               err_code;

    assign wd_expired = &wd_q;

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: clocked state uses <= so every register sees pre-edge values, independent of block order.
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode with event priority: abort latch > link_err > link_ok/activate > timeout.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        done_evt = 1'b0;
        err_evt  = 1'b0;
        err_code = EC_NONE;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len != '0) state_d  = S_WAIT_ACT;
                    else             done_evt = 1'b1;
                end
            end
            S_WAIT_ACT: begin
                if (abort_q) begin
                    state_d  = S_IDLE;
                    err_evt  = 1'b1;
                    err_code = EC_ABORT;
                end else if (i_dma_activate) begin
                    state_d = S_SEND;
                end else if (wd_expired) begin
                    state_d  = S_IDLE;
                    err_evt  = 1'b1;
                    err_code = EC_TIMEOUT;
                end
            end
            S_SEND: begin
                // The FIS always runs to its o_last beat; a pending abort replaces WAIT_LINK.
                if (out_fire && o_last) begin
                    if (abort_q) begin
                        state_d  = S_IDLE;
                        err_evt  = 1'b1;
                        err_code = EC_ABORT;
                    end else begin
                        state_d = S_WAIT_LINK;
                    end
                end
            end
            S_WAIT_LINK: begin
                if (abort_q) begin
                    state_d  = S_IDLE;
                    err_evt  = 1'b1;
                    err_code = EC_ABORT;
                end else if (i_link_err) begin
                    state_d  = S_IDLE;
                    err_evt  = 1'b1;
                    err_code = EC_LINK;
                end else if (i_link_ok) begin
                    if (remaining_q == '0) begin
                        state_d  = S_IDLE;
                        done_evt = 1'b1;
                    end else begin
                        state_d = S_WAIT_ACT;
                    end
                end else if (wd_expired) begin
                    state_d  = S_IDLE;
                    err_evt  = 1'b1;
                    err_code = EC_TIMEOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake decode: the output register refills whenever it is empty or draining.
    always_comb begin
        s_ready  = (state_q == S_SEND) && (!o_valid || i_ready) && (fis_left_q != '0);
        accept   = s_valid && s_ready;
        out_fire = o_valid && i_ready;
    end

    // Watchdog: restarts on every state change and counts only while waiting on the device or link.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wd_q <= '0;
        end else if (state_d != state_q) begin
            wd_q <= '0;
        end else if (state_q == S_WAIT_ACT || state_q == S_WAIT_LINK) begin
            wd_q <= wd_q + LGTIMEOUT'(1);
        end
    end

    // Abort latch: armed by i_abort outside IDLE, dropped whenever the block is or returns to IDLE.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            abort_q <= 1'b0;
        end else if (state_q == S_IDLE || state_d == S_IDLE) begin
            abort_q <= 1'b0;
        end else if (i_abort) begin
            abort_q <= 1'b1;
        end
    end

    // Transfer/FIS counters and the TX gate.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            remaining_q <= '0;
            fis_left_q  <= '0;
            o_txgate    <= 1'b0;
        end else begin
            if (state_q == S_IDLE && i_start) begin
                remaining_q <= i_len;
            end else if (accept) begin
                remaining_q <= remaining_q - LGLEN'(1);
            end

            if (state_q == S_WAIT_ACT && state_d == S_SEND) begin
                fis_left_q <= (remaining_q >= FIS_MAX_L) ? FIS_MAX : remaining_q[LGMAXFIS:0];
                o_txgate   <= 1'b1;
            end else if (accept) begin
                fis_left_q <= fis_left_q - (LGMAXFIS+1)'(1);
                if (fis_left_q == (LGMAXFIS+1)'(1)) o_txgate <= 1'b0;
            end
        end
    end

    // Registered output pipe stage; holds data while the arbiter stalls.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else if (accept) begin
            o_valid <= 1'b1;
            o_data  <= s_data;
            o_last  <= (fis_left_q == (LGMAXFIS+1)'(1));
        end else if (out_fire) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end
    end

    // Status outputs: busy mirrors the next state, done/err are single-cycle pulses.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_errcode <= EC_NONE;
        end else begin
            o_busy <= (state_d != S_IDLE);
            o_done <= done_evt;
            o_err  <= err_evt;
            if (state_q == S_IDLE && i_start) o_errcode <= EC_NONE;
            else if (err_evt)                 o_errcode <= err_code;
        end
    end

endmodule
